// File: rtl/sha_1_avalon_host.sv
// Avalon-MM host that drives a memory-mapped SHA-1 engine for one 512-bit block.
// It writes the 16 message words, starts the engine, polls the done bit with a
// programmable gap, then reads the five digest words back.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake; ready only while idle
//   block_data[511:0]            message block, word 1 in [511:480]
//   digest[159:0]                H0 in [159:128] .. H4 in [31:0]
//   digest_valid, timeout        one-cycle completion / poll-exhausted pulses
//   busy                         high whenever not idle
//   avm_*                        Avalon-MM host port to the SHA-1 register slave
module sha_1_avalon_host #(
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [511:0] block_data,
    output logic [159:0] digest,
    output logic         digest_valid,
    output logic         timeout,
    output logic         busy,
    output logic [4:0]   avm_address,
    output logic         avm_write,
    output logic         avm_read,
    output logic [31:0]  avm_writedata,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_waitrequest
);

    typedef enum logic [2:0] {
        StIdle,
        StWrMsg,
        StWrStart,
        StPoll,
        StGap,
        StRdDig,
        StFinish
    } state_t;

    localparam logic [7:0]  GapLast   = 8'(POLL_GAP - 1);
    localparam logic [16:0] PollLimit = 17'(POLL_LIMIT);

    state_t        state;
    logic [511:0]  msg;
    logic [3:0]    word_cnt;
    logic [15:0]   poll_cnt;
    logic [7:0]    gap_cnt;
    logic          xfer_done;
    logic [16:0]   poll_next;

    assign cmd_ready = (state == StIdle);
    assign busy      = (state != StIdle);
    assign xfer_done = (avm_read | avm_write) & ~avm_waitrequest;
    // One bit wider than the counter so POLL_LIMIT = 65535 compares cleanly.
    assign poll_next = {1'b0, poll_cnt} + 17'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            msg           <= '0;
            word_cnt      <= '0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= '0;
            digest        <= '0;
            digest_valid  <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            timeout      <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        msg           <= block_data;
                        word_cnt      <= '0;
                        avm_address   <= 5'd1;
                        avm_write     <= 1'b1;
                        avm_writedata <= block_data[511:480];
                        state         <= StWrMsg;
                    end
                end
                StWrMsg: begin
                    if (xfer_done) begin
                        if (word_cnt == 4'd15) begin
                            avm_address   <= 5'd0;
                            avm_writedata <= 32'h0000_0001;
                            state         <= StWrStart;
                        end else begin
                            // Rotate so the next word is always the second-from-top slot.
                            msg           <= {msg[479:0], msg[511:480]};
                            avm_writedata <= msg[479:448];
                            avm_address   <= avm_address + 5'd1;
                            word_cnt      <= word_cnt + 4'd1;
                        end
                    end
                end
                StWrStart: begin
                    if (xfer_done) begin
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        poll_cnt      <= '0;
                        if (POLL_GAP == 0) begin
                            avm_read <= 1'b1;
                            state    <= StPoll;
                        end else begin
                            gap_cnt <= '0;
                            state   <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt == GapLast) begin
                        avm_read <= 1'b1;
                        state    <= StPoll;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                StPoll: begin
                    if (xfer_done) begin
                        poll_cnt <= poll_next[15:0];
                        if (avm_readdata[1]) begin
                            avm_address <= 5'd17;
                            state       <= StRdDig;
                        end else if (poll_next == PollLimit) begin
                            avm_read <= 1'b0;
                            timeout  <= 1'b1;
                            state    <= StIdle;
                        end else if (POLL_GAP != 0) begin
                            avm_read <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= StGap;
                        end
                    end
                end
                StRdDig: begin
                    if (xfer_done) begin
                        case (avm_address)
                            5'd17:   digest[159:128] <= avm_readdata;
                            5'd18:   digest[127:96]  <= avm_readdata;
                            5'd19:   digest[95:64]   <= avm_readdata;
                            5'd20:   digest[63:32]   <= avm_readdata;
                            5'd21:   digest[31:0]    <= avm_readdata;
                            default: ;
                        endcase
                        if (avm_address == 5'd21) begin
                            avm_read     <= 1'b0;
                            avm_address  <= 5'd0;
                            digest_valid <= 1'b1;
                            state        <= StFinish;
                        end else begin
                            avm_address <= avm_address + 5'd1;
                        end
                    end
                end
                StFinish: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_1_avalon_host.sv
// Bench for sha_1_avalon_host: a behavioural SHA-1 register slave, a bus
// monitor, a vector table plus hand-written corner-case sequences.
module tb_sha_1_avalon_host;

    localparam int GAP   = 2;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [511:0] block_data = '0;
    logic [159:0] digest;
    logic         digest_valid;
    logic         timeout;
    logic         busy;
    logic [4:0]   avm_address;
    logic         avm_write;
    logic         avm_read;
    logic [31:0]  avm_writedata;
    logic [31:0]  avm_readdata;
    logic         avm_waitrequest;

    always #5 clk = ~clk;

    sha_1_avalon_host #(
        .POLL_GAP   (GAP),
        .POLL_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .block_data      (block_data),
        .digest          (digest),
        .digest_valid    (digest_valid),
        .timeout         (timeout),
        .busy            (busy),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference SHA-1 (single block from the standard IV) ----------------
    function automatic logic [159:0] sha1_ref(input logic [511:0] blk);
        logic [31:0] w [0:79];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c,
                32'h10325476 + d, 32'hC3D2E1F0 + e};
    endfunction

    // ---------------- SHA-1 register slave model ----------------
    logic [31:0]  s_msg [1:16];
    logic [159:0] s_dig = '0;
    int           s_reads = 0;
    int           need_polls = 1;    // done is reported on this status read
    bit           never_done = 1'b0;
    int           stall_addr = -1;
    int           stall_cnt = 0;

    function automatic logic [511:0] pack_msg();
        logic [511:0] r;
        for (int i = 1; i <= 16; i++) r[543 - 32*i -: 32] = s_msg[i];
        return r;
    endfunction

    always_comb begin
        avm_readdata = '0;
        case (avm_address)
            5'd0:    avm_readdata[1] = !never_done && (s_reads + 1 >= need_polls);
            5'd17:   avm_readdata = s_dig[159:128];
            5'd18:   avm_readdata = s_dig[127:96];
            5'd19:   avm_readdata = s_dig[95:64];
            5'd20:   avm_readdata = s_dig[63:32];
            5'd21:   avm_readdata = s_dig[31:0];
            default: ;
        endcase
    end

    assign avm_waitrequest = avm_write && (int'(avm_address) == stall_addr) && (stall_cnt < 3);

    always @(posedge clk) begin
        stall_cnt <= (avm_write && int'(avm_address) == stall_addr) ? stall_cnt + 1 : 0;
        if (avm_write && !avm_waitrequest) begin
            if (avm_address >= 5'd1 && avm_address <= 5'd16) begin
                s_msg[avm_address] <= avm_writedata;
            end else if (avm_address == 5'd0 && avm_writedata[0]) begin
                s_dig   <= sha1_ref(pack_msg());
                s_reads <= 0;
            end
        end
        if (avm_read && !avm_waitrequest && avm_address == 5'd0) s_reads <= s_reads + 1;
    end

    // ---------------- bus monitor (samples mid-cycle) ----------------
    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } xfer_t;

    xfer_t        wr_q[$];
    xfer_t        rd_q[$];
    int           acc_q[$];
    int           dv_cyc_q[$];
    logic [159:0] dv_dig_q[$];
    int           to_q[$];
    int           hold_stall = 0;
    int           proto_errs = 0;
    logic         p_stall = 1'b0;
    logic [4:0]   p_addr = '0;
    logic [31:0]  p_data = '0;
    logic         p_wr = 1'b0;
    logic         p_rd = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_read && avm_write) proto_errs++;
            if (!avm_write && avm_writedata != 32'h0) proto_errs++;
            if (p_stall && (avm_address != p_addr || avm_writedata != p_data ||
                            avm_write != p_wr || avm_read != p_rd)) proto_errs++;
            if (avm_write && int'(avm_address) == stall_addr) hold_stall++;
            if (avm_write && !avm_waitrequest)
                wr_q.push_back('{addr: int'(avm_address), data: avm_writedata, cyc: cyc});
            if (avm_read && !avm_waitrequest)
                rd_q.push_back('{addr: int'(avm_address), data: avm_readdata, cyc: cyc});
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (digest_valid) begin
                dv_cyc_q.push_back(cyc);
                dv_dig_q.push_back(digest);
            end
            if (timeout) to_q.push_back(cyc);
        end
        p_stall = (avm_read || avm_write) && avm_waitrequest;
        p_addr  = avm_address;
        p_data  = avm_writedata;
        p_wr    = avm_write;
        p_rd    = avm_read;
    end

    // ---------------- helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete(); rd_q.delete(); acc_q.delete();
        dv_cyc_q.delete(); dv_dig_q.delete(); to_q.delete();
        hold_stall = 0;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic run_block(input logic [511:0] blk, input int polls, input bit nd);
        clear_mon();
        need_polls = polls;
        never_done = nd;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        block_data = blk;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (acc_q.size() > 0) break;
        end
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        block_data = rand_block();  // must not affect the block in flight
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dv_cyc_q.size() > 0 || to_q.size() > 0) break;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic verify_block(input string tag, input logic [511:0] blk, input logic [159:0] exp,
                                input int polls, input int extra);
        int acc, bad, ea;
        logic [31:0] ed;
        acc = (acc_q.size() > 0) ? acc_q[0] : -1000;
        check_int({tag, "_wr_count"}, wr_q.size(), 17);
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < 17; i++) begin
            ea = (i < 16) ? i + 1 : 0;
            ed = (i < 16) ? blk[511 - 32*i -: 32] : 32'h1;
            if (wr_q[i].addr != ea || wr_q[i].data != ed) bad++;
        end
        check_int({tag, "_wr_seq_errs"}, bad, 0);
        check_int({tag, "_rd_count"}, rd_q.size(), polls + 5);
        bad = 0;
        for (int i = 0; i < rd_q.size(); i++) begin
            ea = (i < polls) ? 0 : 17 + i - polls;
            if (rd_q[i].addr != ea) bad++;
            if (i > 0 && i < polls && rd_q[i].cyc - rd_q[i-1].cyc != GAP + 1) bad++;
        end
        check_int({tag, "_rd_seq_errs"}, bad, 0);
        check_int({tag, "_poll_latency"}, (rd_q.size() > 0) ? rd_q[0].cyc - acc : -1,
                  18 + GAP + extra);
        check_int({tag, "_dv_pulses"}, dv_cyc_q.size(), 1);
        check_int({tag, "_timeouts"}, to_q.size(), 0);
        check_vec({tag, "_digest"}, (dv_dig_q.size() > 0) ? dv_dig_q[0] : '0, exp);
    endtask

    typedef struct {
        logic [511:0] blk;
        logic [159:0] exp;
        int           polls;
    } vec_t;

    vec_t         vecs[6];
    logic [159:0] last_dig;
    logic [511:0] blk_a, blk_b;
    int           found;

    initial begin
        // vector table: two known SHA-1 answers, then random blocks against the model
        vecs[0].blk = '0;
        vecs[0].blk[511:480] = 32'h61626380;
        vecs[0].blk[31:0]    = 32'h00000018;
        vecs[0].exp   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
        vecs[0].polls = 1;
        vecs[1].blk = '0;
        vecs[1].blk[511:480] = 32'h80000000;
        vecs[1].exp   = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;
        vecs[1].polls = LIMIT;   // done on the last permitted poll
        for (int i = 2; i < 6; i++) begin
            vecs[i].blk   = rand_block();
            vecs[i].exp   = sha1_ref(vecs[i].blk);
            vecs[i].polls = int'($urandom_range(1, LIMIT));
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("rst_cmd_ready", int'(cmd_ready), 1);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_strobes", int'(avm_read) + int'(avm_write), 0);
        check_int("rst_addr", int'(avm_address), 0);
        check_vec("rst_digest", digest, '0);
        check_int("rst_pulses", int'(digest_valid) + int'(timeout), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_mon();
        @(negedge clk);
        check_int("post_rst_ready", int'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        check_int("post_rst_no_xfers", wr_q.size() + rd_q.size(), 0);

        // table-driven blocks
        for (int v = 0; v < 6; v++) begin
            run_block(vecs[v].blk, vecs[v].polls, 1'b0);
            verify_block($sformatf("vec%0d", v), vecs[v].blk, vecs[v].exp, vecs[v].polls, 0);
            check_vec($sformatf("vec%0d_digest_port", v), digest, vecs[v].exp);
        end
        last_dig = vecs[5].exp;

        // done never set: poll limit exhausted
        run_block(rand_block(), 1, 1'b1);
        check_int("to_pulses", to_q.size(), 1);
        check_int("to_dv_pulses", dv_cyc_q.size(), 0);
        check_int("to_reads", rd_q.size(), LIMIT);
        found = 0;
        for (int i = 0; i < rd_q.size(); i++) begin
            if (rd_q[i].addr != 0) found++;
            if (i > 0 && rd_q[i].cyc - rd_q[i-1].cyc != GAP + 1) found++;
        end
        check_int("to_read_pattern_errs", found, 0);
        check_vec("to_digest_kept", digest, last_dig);
        check_int("to_busy_after", int'(busy), 0);

        // waitrequest held for 3 cycles on the write to address 5
        stall_addr = 5;
        run_block(vecs[3].blk, 2, 1'b0);
        stall_addr = -1;
        verify_block("stall", vecs[3].blk, vecs[3].exp, 2, 3);
        check_int("stall_hold_cycles", hold_stall, 4);

        // reset in the middle of the write to address 8
        clear_mon();
        need_polls = 1;
        never_done = 1'b0;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        block_data = vecs[2].blk;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (acc_q.size() > 0) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (avm_write && avm_address == 5'd8) begin
                found = 1;
                break;
            end
        end
        check_int("rst_mid_found_addr8", found, 1);
        #1 reset = 1'b1;
        #1;
        check_int("rst_mid_write", int'(avm_write), 0);
        check_int("rst_mid_read", int'(avm_read), 0);
        check_int("rst_mid_addr", int'(avm_address), 0);
        check_int("rst_mid_wdata", int'(avm_writedata != 32'h0), 0);
        check_int("rst_mid_busy", int'(busy), 0);
        check_vec("rst_mid_digest", digest, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_mon();
        @(negedge clk);
        check_int("rst_mid_ready", int'(cmd_ready), 1);
        check_int("rst_mid_quiet", int'(avm_read) + int'(avm_write), 0);
        run_block(vecs[0].blk, 3, 1'b0);
        verify_block("after_rst", vecs[0].blk, vecs[0].exp, 3, 0);

        // cmd_valid held across two blocks
        clear_mon();
        blk_a = rand_block();
        blk_b = rand_block();
        need_polls = 1;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        block_data = blk_a;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dv_cyc_q.size() > 0) break;
        end
        block_data = blk_b;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (acc_q.size() > 1) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dv_cyc_q.size() > 1) break;
        end
        repeat (4) @(negedge clk);
        check_int("b2b_accepts", acc_q.size(), 2);
        check_int("b2b_dv_pulses", dv_cyc_q.size(), 2);
        check_int("b2b_accept_gap", (acc_q.size() > 1 && dv_cyc_q.size() > 0) ?
                  acc_q[1] - dv_cyc_q[0] : -1, 1);
        check_vec("b2b_digest_a", (dv_dig_q.size() > 0) ? dv_dig_q[0] : '0, sha1_ref(blk_a));
        check_vec("b2b_digest_b", (dv_dig_q.size() > 1) ? dv_dig_q[1] : '0, sha1_ref(blk_b));

        check_int("protocol_errs", proto_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha_1_avalon_host.md
SHA_1_AVALON_HOST -- requirements
Module: sha_1_avalon_host

Interface
REQ-001 Parameter POLL_GAP, default 4: idle cycles between consecutive status polls (range 0..255).
REQ-002 Parameter POLL_LIMIT, default 1024: maximum status reads before timeout (range 1..65535).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  request to hash one 512-bit block.
REQ-006 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-007 block_data  input  512  message block; word k (1..16) = block_data[543-32k -: 32].
REQ-008 digest  output  160  result; H0 in [159:128] through H4 in [31:0].
REQ-009 digest_valid  output  1  one-cycle pulse when digest is updated.
REQ-010 timeout  output  1  one-cycle pulse when POLL_LIMIT is exhausted.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 avm_address  output  5  word address into the SHA-1 register slave.
REQ-013 avm_write / avm_read  output  1 each  Avalon-MM command strobes; never both high.
REQ-014 avm_writedata  output  32  write data.
REQ-015 avm_readdata  input  32  read data; valid in the cycle the read completes (zero-latency slave).
REQ-016 avm_waitrequest  input  1  slave stall; tie low for the existing slave.

Function
REQ-017 Register map: 0 = control/status (bit0 start, bit1 done); 1..16 = message words; 17..21 = digest H0..H4.
REQ-018 A transfer completes in a cycle where avm_read or avm_write is high and avm_waitrequest is low.
REQ-019 While a transfer is stalled, avm_address, avm_writedata and the strobes are held stable.
REQ-020 States: IDLE, WR_MSG, WR_START, POLL, GAP, RD_DIG, FINISH.
REQ-021 IDLE: on accept, latch block_data into an internal 512-bit register, clear the word counter and go to WR_MSG.
REQ-022 WR_MSG: write words 1..16 in ascending address order, one per completed transfer; after address 16 completes, go to WR_START.
REQ-023 WR_START: write 32'h0000_0001 to address 0, which also clears the done bit; on completion clear the poll counter and go to GAP.
REQ-024 GAP: strobes low for POLL_GAP cycles, then go to POLL; with POLL_GAP = 0, go to POLL the next cycle.
REQ-025 POLL: read address 0 and increment the poll counter on completion.
REQ-026 POLL exits: readdata[1] = 1 -> RD_DIG; else poll counter = POLL_LIMIT -> pulse timeout and go to IDLE; else -> GAP.
REQ-027 RD_DIG: read addresses 17..21 in order, storing each completed read into the matching digest slice; after 21, go to FINISH.
REQ-028 FINISH: hold strobes low, pulse digest_valid for one cycle, then go to IDLE.
REQ-029 digest keeps its last value until the next successful RD_DIG; a timeout does not change it.
REQ-030 Minimum latency with no stalls: command accept to first poll read = 17 write cycles + POLL_GAP + 1.
REQ-031 With cmd_valid held high, the next command is accepted in the first IDLE cycle after FINISH or timeout.
REQ-032 cmd_valid is ignored while busy, and block_data changes after accept have no effect.
REQ-033 avm_writedata = 0 whenever avm_write is low.

Reset
REQ-034 Asserting reset at any point, including mid-transfer, forces the following: state IDLE, avm_read = avm_write = 0, avm_address = 0, avm_writedata = 0, digest = 0, digest_valid = 0, timeout = 0, busy = 0, and all counters to 0.
REQ-035 In the first cycle after reset deasserts, cmd_ready = 1 and the block issues no transfers.

Verification
REQ-036 "abc" block (word1 = 32'h61626380, words 2..15 = 0, word16 = 32'h00000018) against the SHA-1 slave model -> digest = A9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D with a single digest_valid pulse.
REQ-037 avm_waitrequest high for 3 cycles during the write to address 5 -> address, data and write strobe held for 4 cycles; exactly 16 message writes occur, with no skipped or duplicated word.
REQ-038 Slave never sets done, POLL_LIMIT = 4, POLL_GAP = 2 -> exactly 4 reads of address 0, 2 idle cycles between them, one timeout pulse, no digest_valid, and digest unchanged.
REQ-039 Reset asserted during the write to address 8 -> strobes drop immediately; after release, cmd_ready = 1 and a new command restarts at address 1.
REQ-040 cmd_valid held high across two blocks -> second accept occurs in the cycle after the first FINISH, and two digest_valid pulses occur with their matching digests.
